// File: rtl/merge_tree_feeder.sv
// Leaf-side buffering for the merge sorter tree: steers tagged records into per-leaf
// FWFT FIFOs and appends an all-ones-key terminator after each run's last record.
module merge_tree_feeder #(
  parameter int W_LOG     = 2,
  parameter int DATW      = 64,
  parameter int KEYW      = 32,
  parameter int FIFO_SIZE = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [DATW-1:0]            IN_DIN,
  input  logic [W_LOG-1:0]           IN_IDX,
  input  logic                       IN_LAST,
  input  logic                       IN_VLD,
  output logic                       IN_RDY,
  input  logic [(1<<W_LOG)-1:0]      TREE_FULL,
  output logic [(DATW<<W_LOG)-1:0]   TREE_DIN,
  output logic [(1<<W_LOG)-1:0]      TREE_DINEN,
  output logic                       BUSY
);

  localparam int NLEAF = 1 << W_LOG;
  localparam int DEPTH = 1 << FIFO_SIZE;

  localparam logic [FIFO_SIZE:0]   CNT_ZERO = {(FIFO_SIZE+1){1'b0}};
  localparam logic [FIFO_SIZE:0]   CNT_FULL = {1'b1, {FIFO_SIZE{1'b0}}};
  localparam logic [FIFO_SIZE:0]   CNT_ONE  = (FIFO_SIZE+1)'(1'b1);
  localparam logic [FIFO_SIZE-1:0] PTR_ZERO = {FIFO_SIZE{1'b0}};
  localparam logic [FIFO_SIZE-1:0] PTR_ONE  = FIFO_SIZE'(1'b1);
  localparam logic [DATW-1:0]      TERM_REC = DATW'({KEYW{1'b1}});

  logic [FIFO_SIZE:0]   cnt_q  [NLEAF];
  logic [FIFO_SIZE:0]   cnt_d  [NLEAF];
  logic [FIFO_SIZE-1:0] head_q [NLEAF];
  logic [FIFO_SIZE-1:0] head_d [NLEAF];
  logic [FIFO_SIZE-1:0] tail_q [NLEAF];
  logic [FIFO_SIZE-1:0] tail_d [NLEAF];
  logic [NLEAF-1:0]     term_pend_q;
  logic [NLEAF-1:0]     term_pend_d;
  logic [DATW-1:0]      mem_q  [NLEAF][DEPTH];

  logic [NLEAF-1:0]     empty_s;
  logic [NLEAF-1:0]     full_s;
  logic [NLEAF-1:0]     deq_s;
  logic [NLEAF-1:0]     in_wr_s;
  logic [NLEAF-1:0]     term_wr_s;
  logic [NLEAF-1:0]     wr_s;
  logic [DATW-1:0]      wdata_s [NLEAF];
  logic                 accept_s;

  // Per-leaf occupancy flags derived from the registered counts.
  always_comb begin
    empty_s = {NLEAF{1'b0}};
    full_s  = {NLEAF{1'b0}};
    for (int i = 0; i < NLEAF; i++) begin
      empty_s[i] = (cnt_q[i] == CNT_ZERO);
      full_s[i]  = (cnt_q[i] == CNT_FULL);
    end
  end

  // A pending terminator owns its leaf's write port, so input is held off until it lands.
  assign IN_RDY   = ~full_s[IN_IDX] & ~term_pend_q[IN_IDX];
  assign accept_s = IN_VLD & IN_RDY;

  // Write/read arbitration and next-state for counts, pointers and terminator flags.
  always_comb begin
    deq_s       = {NLEAF{1'b0}};
    in_wr_s     = {NLEAF{1'b0}};
    term_wr_s   = {NLEAF{1'b0}};
    wr_s        = {NLEAF{1'b0}};
    term_pend_d = term_pend_q;
    for (int i = 0; i < NLEAF; i++) begin
      deq_s[i]     = ~empty_s[i] & ~TREE_FULL[i];
      in_wr_s[i]   = accept_s & (IN_IDX == W_LOG'(i));
      term_wr_s[i] = term_pend_q[i] & ~full_s[i];
      wr_s[i]      = in_wr_s[i] | term_wr_s[i];

      if (term_wr_s[i]) begin
        wdata_s[i] = TERM_REC;
      end else begin
        wdata_s[i] = IN_DIN;
      end

      case ({wr_s[i], deq_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
        default: cnt_d[i] = cnt_q[i];
      endcase

      if (wr_s[i]) begin
        tail_d[i] = tail_q[i] + PTR_ONE;
      end else begin
        tail_d[i] = tail_q[i];
      end

      if (deq_s[i]) begin
        head_d[i] = head_q[i] + PTR_ONE;
      end else begin
        head_d[i] = head_q[i];
      end

      if (in_wr_s[i] & IN_LAST) begin
        term_pend_d[i] = 1'b1;
      end else if (term_wr_s[i]) begin
        term_pend_d[i] = 1'b0;
      end else begin
        term_pend_d[i] = term_pend_q[i];
      end
    end
  end

  // Control state; reset drops all buffered records and pending terminators.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NLEAF; i++) begin
        cnt_q[i]  <= CNT_ZERO;
        head_q[i] <= PTR_ZERO;
        tail_q[i] <= PTR_ZERO;
      end
      term_pend_q <= {NLEAF{1'b0}};
    end else begin
      for (int i = 0; i < NLEAF; i++) begin
        cnt_q[i]  <= cnt_d[i];
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
      end
      term_pend_q <= term_pend_d;
    end
  end

  // FIFO storage, one write port per leaf; contents survive reset.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NLEAF; i++) begin
      if (wr_s[i]) begin
        mem_q[i][tail_q[i]] <= wdata_s[i];
      end
    end
  end

  // Fall-through heads and enables toward the tree.
  always_comb begin
    TREE_DIN = {(DATW<<W_LOG){1'b0}};
    for (int i = 0; i < NLEAF; i++) begin
      TREE_DIN[i*DATW +: DATW] = mem_q[i][head_q[i]];
    end
    TREE_DINEN = deq_s;
    BUSY       = (~&empty_s) | (|term_pend_q);
  end

endmodule

// File: tb/tb_merge_tree_feeder.sv
// Directed bench for merge_tree_feeder at W_LOG=2, DATW=64, KEYW=32, FIFO_SIZE=2.
module tb_merge_tree_feeder;

  logic         CLK;
  logic         RST;
  logic [63:0]  IN_DIN;
  logic [1:0]   IN_IDX;
  logic         IN_LAST;
  logic         IN_VLD;
  logic         IN_RDY;
  logic [3:0]   TREE_FULL;
  logic [255:0] TREE_DIN;
  logic [3:0]   TREE_DINEN;
  logic         BUSY;

  int total;
  int bad;

  localparam logic [63:0] TERM = 64'h0000_0000_FFFF_FFFF;

  merge_tree_feeder #(.W_LOG(2), .DATW(64), .KEYW(32), .FIFO_SIZE(2)) dut (
    .CLK(CLK), .RST(RST), .IN_DIN(IN_DIN), .IN_IDX(IN_IDX), .IN_LAST(IN_LAST),
    .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .TREE_FULL(TREE_FULL), .TREE_DIN(TREE_DIN),
    .TREE_DINEN(TREE_DINEN), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [63:0] rec(input logic [31:0] k);
    return {32'h0000_00AB, k};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [1:0] idx, input logic [31:0] k, input logic last);
    IN_VLD  = vld;
    IN_IDX  = idx;
    IN_DIN  = rec(k);
    IN_LAST = last;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; TREE_FULL = 4'b0000;
    drive(1'b1, 2'd0, 32'd99, 1'b1);
    tick(); tick();
    total++; if (TREE_DINEN !== 4'b0000) begin bad++; $display("FAIL reset_dinen got=%b want=0000", TREE_DINEN); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", BUSY); end
    RST = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", IN_RDY); end
    tick();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", BUSY); end
  endtask

  task automatic test_passthrough();
    TREE_FULL = 4'b0000;
    drive(1'b1, 2'd2, 32'd5, 1'b0);
    total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL pass_rdy got=%b want=1", IN_RDY); end
    tick();
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    total++; if (TREE_DINEN !== 4'b0100) begin bad++; $display("FAIL pass_dinen got=%b want=0100", TREE_DINEN); end
    total++; if (TREE_DIN[128 +: 64] !== rec(32'd5)) begin bad++; $display("FAIL pass_data got=%h want=%h", TREE_DIN[128 +: 64], rec(32'd5)); end
    tick();
    total++; if (TREE_DINEN !== 4'b0000) begin bad++; $display("FAIL pass_after got=%b want=0000", TREE_DINEN); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL pass_busy got=%b want=0", BUSY); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_keys [5];
    exp_keys = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    TREE_FULL = 4'b1111;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 2'd0, 32'(k), 1'b0);
      total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL bp_fill_rdy k=%0d got=%b want=1", k, IN_RDY); end
      tick();
    end
    drive(1'b1, 2'd0, 32'd5, 1'b0);
    total++; if (IN_RDY !== 1'b0) begin bad++; $display("FAIL bp_full_rdy got=%b want=0", IN_RDY); end
    total++; if (TREE_DINEN !== 4'b0000) begin bad++; $display("FAIL bp_held got=%b want=0000", TREE_DINEN); end
    TREE_FULL = 4'b1110;
    #1;
    total++; if (IN_RDY !== 1'b0) begin bad++; $display("FAIL bp_full_deq_rdy got=%b want=0", IN_RDY); end
    for (int j = 0; j < 5; j++) begin
      if (j == 1) begin
        total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL bp_recover_rdy got=%b want=1", IN_RDY); end
      end
      if (j == 2) drive(1'b0, 2'd0, 32'd0, 1'b0);
      total++; if (TREE_DINEN !== 4'b0001) begin bad++; $display("FAIL bp_dinen j=%0d got=%b want=0001", j, TREE_DINEN); end
      total++; if (TREE_DIN[0 +: 64] !== rec(exp_keys[j])) begin bad++; $display("FAIL bp_order j=%0d got=%h want=%h", j, TREE_DIN[0 +: 64], rec(exp_keys[j])); end
      tick();
    end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL bp_busy got=%b want=0", BUSY); end
  endtask

  task automatic test_terminator();
    logic [63:0] exp_recs [3];
    exp_recs = '{rec(32'd7), rec(32'd9), TERM};
    TREE_FULL = 4'b1000;
    drive(1'b1, 2'd3, 32'd7, 1'b0);
    total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL term_rdy7 got=%b want=1", IN_RDY); end
    tick();
    drive(1'b1, 2'd3, 32'd9, 1'b1);
    total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL term_rdy9 got=%b want=1", IN_RDY); end
    tick();
    drive(1'b1, 2'd3, 32'd11, 1'b0);
    total++; if (IN_RDY !== 1'b0) begin bad++; $display("FAIL term_pend_rdy got=%b want=0", IN_RDY); end
    tick();
    drive(1'b0, 2'd3, 32'd0, 1'b0);
    total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL term_clear_rdy got=%b want=1", IN_RDY); end
    TREE_FULL = 4'b0000;
    #1;
    for (int j = 0; j < 3; j++) begin
      total++; if (TREE_DINEN !== 4'b1000) begin bad++; $display("FAIL term_dinen j=%0d got=%b want=1000", j, TREE_DINEN); end
      total++; if (TREE_DIN[192 +: 64] !== exp_recs[j]) begin bad++; $display("FAIL term_order j=%0d got=%h want=%h", j, TREE_DIN[192 +: 64], exp_recs[j]); end
      tick();
    end
    total++; if (TREE_DINEN !== 4'b0000) begin bad++; $display("FAIL term_done got=%b want=0000", TREE_DINEN); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL term_busy got=%b want=0", BUSY); end
  endtask

  task automatic test_term_blocked();
    logic [63:0] exp_recs [5];
    exp_recs = '{rec(32'd21), rec(32'd22), rec(32'd23), rec(32'd24), TERM};
    TREE_FULL = 4'b0010;
    for (int k = 21; k <= 24; k++) begin
      drive(1'b1, 2'd1, 32'(k), (k == 24) ? 1'b1 : 1'b0);
      total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL blk_fill_rdy k=%0d got=%b want=1", k, IN_RDY); end
      tick();
    end
    drive(1'b1, 2'd1, 32'd25, 1'b0);
    total++; if (IN_RDY !== 1'b0) begin bad++; $display("FAIL blk_rdy1_a got=%b want=0", IN_RDY); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL blk_busy_a got=%b want=1", BUSY); end
    tick();
    drive(1'b1, 2'd0, 32'd31, 1'b0);
    total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL blk_leaf0_rdy got=%b want=1", IN_RDY); end
    tick();
    drive(1'b0, 2'd1, 32'd0, 1'b0);
    total++; if (IN_RDY !== 1'b0) begin bad++; $display("FAIL blk_rdy1_b got=%b want=0", IN_RDY); end
    total++; if (TREE_DINEN !== 4'b0001) begin bad++; $display("FAIL blk_leaf0_dinen got=%b want=0001", TREE_DINEN); end
    total++; if (TREE_DIN[0 +: 64] !== rec(32'd31)) begin bad++; $display("FAIL blk_leaf0_data got=%h want=%h", TREE_DIN[0 +: 64], rec(32'd31)); end
    tick();
    TREE_FULL = 4'b0000;
    #1;
    for (int j = 0; j < 5; j++) begin
      if (j < 2) begin
        total++; if (IN_RDY !== 1'b0) begin bad++; $display("FAIL blk_rel_rdy j=%0d got=%b want=0", j, IN_RDY); end
      end
      if (j == 2) begin
        total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL blk_term_written got=%b want=1", IN_RDY); end
      end
      total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL blk_busy j=%0d got=%b want=1", j, BUSY); end
      total++; if (TREE_DINEN !== 4'b0010) begin bad++; $display("FAIL blk_dinen j=%0d got=%b want=0010", j, TREE_DINEN); end
      total++; if (TREE_DIN[64 +: 64] !== exp_recs[j]) begin bad++; $display("FAIL blk_order j=%0d got=%h want=%h", j, TREE_DIN[64 +: 64], exp_recs[j]); end
      tick();
    end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL blk_busy_end got=%b want=0", BUSY); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] keys [4];
    keys = '{32'd51, 32'd52, 32'd53, 32'd54};
    TREE_FULL = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), keys[i], (i == 1) ? 1'b1 : 1'b0);
      total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL b2b_rdy i=%0d got=%b want=1", i, IN_RDY); end
      tick();
    end
    drive(1'b0, 2'd0, 32'd0, 1'b0);
    TREE_FULL = 4'b0000;
    #1;
    total++; if (TREE_DINEN !== 4'b1111) begin bad++; $display("FAIL b2b_par_dinen got=%b want=1111", TREE_DINEN); end
    for (int i = 0; i < 4; i++) begin
      total++; if (TREE_DIN[64*i +: 64] !== rec(keys[i])) begin bad++; $display("FAIL b2b_par_data i=%0d got=%h want=%h", i, TREE_DIN[64*i +: 64], rec(keys[i])); end
    end
    tick();
    total++; if (TREE_DINEN !== 4'b0010) begin bad++; $display("FAIL b2b_term_dinen got=%b want=0010", TREE_DINEN); end
    total++; if (TREE_DIN[64 +: 64] !== TERM) begin bad++; $display("FAIL b2b_term_data got=%h want=%h", TREE_DIN[64 +: 64], TERM); end
    tick();
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL b2b_busy got=%b want=0", BUSY); end
  endtask

  task automatic test_midrun_reset();
    TREE_FULL = 4'b1111;
    drive(1'b1, 2'd2, 32'd41, 1'b0); tick();
    drive(1'b1, 2'd2, 32'd42, 1'b0); tick();
    drive(1'b1, 2'd2, 32'd43, 1'b1); tick();
    drive(1'b0, 2'd2, 32'd0, 1'b0);
    total++; if (IN_RDY !== 1'b0) begin bad++; $display("FAIL mrst_pend_rdy got=%b want=0", IN_RDY); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mrst_busy_pre got=%b want=1", BUSY); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    TREE_FULL = 4'b0000;
    #1;
    total++; if (TREE_DINEN !== 4'b0000) begin bad++; $display("FAIL mrst_dinen got=%b want=0000", TREE_DINEN); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%b want=0", BUSY); end
    for (int i = 0; i < 4; i++) begin
      IN_IDX = 2'(i);
      #1;
      total++; if (IN_RDY !== 1'b1) begin bad++; $display("FAIL mrst_rdy i=%0d got=%b want=1", i, IN_RDY); end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (TREE_DINEN !== 4'b0000) begin bad++; $display("FAIL mrst_noterm c=%0d got=%b want=0000", c, TREE_DINEN); end
      total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mrst_idle c=%0d got=%b want=0", c, BUSY); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST = 1'b1;
    IN_VLD = 1'b0;
    IN_IDX = 2'd0;
    IN_DIN = 64'd0;
    IN_LAST = 1'b0;
    TREE_FULL = 4'b0000;
    test_reset();
    test_passthrough();
    test_backpressure();
    test_terminator();
    test_term_blocked();
    test_back_to_back();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
